// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Decimal digits needed to show 2^width-1.
  function automatic int min_digits(input int width);
    longint unsigned v;
    int d;
    v = (64'd1 << width) - 64'd1;
    d = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        d++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the double-dabble adjust: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  // Max result is 9+3=12, so no carry into the next digit.
  assign adj = (digit >= BCD_ADJ_THRESH) ? digit + BCD_ADJ_ADD : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter with valid/ready handshakes.
// Define BIN2BCD_BLANK_EN to build the leading-zero blanking mask.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  if (DIGITS < min_digits(WIDTH)) begin : g_narrow
    $warning("bin2bcd_seq: DIGITS=%0d cannot hold all WIDTH=%0d values, ovf may assert",
             DIGITS, WIDTH);
  end

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]    acc, adj, acc_shift;
  logic             ovf_r;
  logic             last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (acc[4*g +: 4]),
      .adj   (adj[4*g +: 4])
    );
  end

  assign last      = (cnt == CW'(1));
  assign acc_shift = {adj[BW-2:0], sreg[WIDTH-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      sreg  <= '0;
      acc   <= '0;
      ovf_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sreg  <= bin;
          acc   <= '0;
          ovf_r <= 1'b0;
          cnt   <= CW'(WIDTH);
        end
        SHIFT: begin
          acc   <= acc_shift;
          sreg  <= sreg << 1;
          // The top digit's MSB falls off the accumulator: value no longer fits.
          ovf_r <= ovf_r | adj[BW-1];
          cnt   <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bcd = acc;
  assign ovf = ovf_r;

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_nxt, blank_r;
  logic              hi_zero;

  always_comb begin
    blank_nxt = '0;
    hi_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero      = hi_zero & (acc_shift[4*i +: 4] == 4'd0);
      blank_nxt[i] = hi_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     blank_r <= '0;
    else if (state == SHIFT && last) blank_r <= blank_nxt;
  end

  assign blank = blank_r;
`else
  assign blank = '0;
`endif

endmodule
